// File: rtl/riscv_ir_imm_alu.sv
// Multicycle RV32I datapath slice: instruction register with old-PC latch, field decode,
// immediate extender and ALU with a registered result.
module riscv_ir_imm_alu #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] IR_RESET = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ir_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] read_data,
    input  logic [1:0]      imm_src,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] alu_out,
    output logic            zero
);

    logic [XLEN-1:0]        ir_p1;
    logic [XLEN-1:0]        old_pc_p1;
    logic [XLEN-1:0]        alu_out_p1;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    // Stage p1: instruction fetch capture (IR and the PC it came from load together)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_p1     <= IR_RESET;
            old_pc_p1 <= '0;
        end else if (ir_write) begin
            ir_p1     <= read_data;
            old_pc_p1 <= pc;
        end
    end

    assign instr  = ir_p1;
    assign old_pc = old_pc_p1;
    assign opcode = ir_p1[6:0];
    assign rd     = ir_p1[11:7];
    assign func3  = ir_p1[14:12];
    assign rs1    = ir_p1[19:15];
    assign rs2    = ir_p1[24:20];
    assign func7  = ir_p1[31:25];

    always_comb begin
        imm_ext = '0;
        unique case (imm_src)
            2'b00: imm_ext = {{20{ir_p1[31]}}, ir_p1[31:20]};
            2'b01: imm_ext = {{20{ir_p1[31]}}, ir_p1[31:25], ir_p1[11:7]};
            2'b10: imm_ext = {{20{ir_p1[31]}}, ir_p1[7], ir_p1[30:25], ir_p1[11:8], 1'b0};
            2'b11: imm_ext = {{12{ir_p1[31]}}, ir_p1[19:12], ir_p1[20], ir_p1[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    assign a_s = src_a;
    assign b_s = src_b;

    always_comb begin
        alu_result = '0;
        unique case (alu_control)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            3'b101: alu_result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            3'b110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            3'b111: alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Stage p1: ALU result register, free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) alu_out_p1 <= '0;
        else        alu_out_p1 <= alu_result;
    end

    assign alu_out = alu_out_p1;

endmodule

// File: tb/tb_riscv_ir_imm_alu.sv
// Scoreboard bench for riscv_ir_imm_alu: directed vectors then randomized cycles.
module tb_riscv_ir_imm_alu;

    logic        clk;
    logic        reset;
    logic        ir_write;
    logic [31:0] pc, read_data, src_a, src_b;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic [31:0] instr, old_pc, imm_ext, alu_result, alu_out;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic        zero;

    riscv_ir_imm_alu dut (
        .clk(clk), .reset(reset), .ir_write(ir_write), .pc(pc), .read_data(read_data),
        .imm_src(imm_src), .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .instr(instr), .old_pc(old_pc), .opcode(opcode), .rd(rd), .func3(func3),
        .rs1(rs1), .rs2(rs2), .func7(func7), .imm_ext(imm_ext), .alu_result(alu_result),
        .alu_out(alu_out), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] opc;
        logic [31:0] imm;
        logic [31:0] res;
        logic [31:0] aout;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_ir   = 32'h0000_0013;
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_aout = 32'h0;

    function automatic logic [31:0] ref_imm(input logic [31:0] ir, input logic [1:0] sel);
        int v;
        case (sel)
            2'd0: v = $signed(ir[31:20]);
            2'd1: v = $signed({ir[31:25], ir[11:7]});
            2'd2: v = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
            default: v = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint unsigned ua, ub;
        int sa, sb2;
        ua = a; ub = b; sa = a; sb2 = b;
        case (op)
            3'd0: return 32'((ua + ub) % 64'h1_0000_0000);
            3'd1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb2) ? 32'd1 : 32'd0;
            3'd6: return (ua < ub) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, push what the outputs must show before the next edge.
    task automatic step(input logic rst, input logic irw, input logic [31:0] p,
                        input logic [31:0] rdata, input logic [1:0] isrc,
                        input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; ir_write = irw; pc = p; read_data = rdata;
        imm_src = isrc; alu_control = op; src_a = a; src_b = b;
        if (!rst) begin
            m_ir = 32'h0000_0013; m_pc = 32'h0; m_aout = 32'h0;
        end
        e.ir   = m_ir;
        e.opc  = m_pc;
        e.imm  = ref_imm(m_ir, isrc);
        e.res  = ref_alu(a, b, op);
        e.aout = m_aout;
        e.z    = (e.res == 32'h0);
        sb.push_back(e);
        if (rst) begin
            if (irw) begin
                m_ir = rdata; m_pc = p;
            end
            m_aout = e.res;
        end
    endtask

    // Monitor: every mid-cycle the DUT presents a full output set; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr", instr, e.ir);
                check("old_pc", old_pc, e.opc);
                check("opcode", {25'h0, opcode}, {25'h0, e.ir[6:0]});
                check("rd", {27'h0, rd}, {27'h0, e.ir[11:7]});
                check("func3", {29'h0, func3}, {29'h0, e.ir[14:12]});
                check("rs1", {27'h0, rs1}, {27'h0, e.ir[19:15]});
                check("rs2", {27'h0, rs2}, {27'h0, e.ir[24:20]});
                check("func7", {25'h0, func7}, {25'h0, e.ir[31:25]});
                check("imm_ext", imm_ext, e.imm);
                check("alu_result", alu_result, e.res);
                check("zero", {31'h0, zero}, {31'h0, e.z});
                check("alu_out", alu_out, e.aout);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b0; ir_write = 1'b0; pc = '0; read_data = '0;
        imm_src = '0; alu_control = '0; src_a = '0; src_b = '0;

        step(0, 0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);
        step(0, 1, 32'h20, 32'hDEAD_BEEF, 2'd0, 3'd0, 32'h3, 32'h4);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);
        step(1, 1, 32'h10, 32'hFFC1_0093, 2'd0, 3'd3, 32'h1, 32'h2);
        step(1, 0, 32'h99, 32'h1234_5678, 2'd0, 3'd0, 32'h0, 32'h0);
        step(1, 0, 32'h77, 32'h8765_4321, 2'd0, 3'd4, 32'hF0F0, 32'h0FF0);
        step(1, 1, 32'h40, 32'hFE00_08E3, 2'd2, 3'd0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 32'h0, 2'd2, 3'd2, 32'hFF00, 32'h0FF0);
        step(1, 1, 32'h44, 32'h0080_006F, 2'd3, 3'd0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 32'h0, 2'd3, 3'd7, 32'h0, 32'hABCD);
        step(1, 1, 32'h48, 32'h0011_2423, 2'd1, 3'd0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 32'h0, 2'd1, 3'd0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd1, 32'h5, 32'h5);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd5, 32'hFFFF_FFFF, 32'h1);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd6, 32'hFFFF_FFFF, 32'h1);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'h1);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd1, 32'h0, 32'h1);
        step(1, 1, 32'h50, 32'h0000_0000, 2'd0, 3'd0, 32'h0, 32'h0);
        step(0, 1, 32'h54, 32'h1234_5678, 2'd0, 3'd3, 32'h6, 32'h1);
        step(1, 0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), $urandom, $urandom,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ra, rb);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
